// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared pipeline definitions: default datapath width, ALU
//                operation codes and operand forward-select codes.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Default datapath width used by every pipeline stage
    localparam int DEFAULT_WIDTH = 32;

    // ALU operation codes; 3'b110 and 3'b111 are reserved and yield zero
    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_AND = 3'b010,
        ALU_OR  = 3'b011,
        ALU_XOR = 3'b100,
        ALU_SLT = 3'b101
    } alu_op_e;

    // Operand forward selects; 2'b11 falls back to the register-file value
    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/alu.sv
`default_nettype none
// ============================================================================
//  Module      : alu
//  Description : Combinational integer ALU for the execute stage. Add and
//                subtract wrap modulo 2^WIDTH; SLT is a signed compare with
//                a zero-extended 0/1 result; reserved op codes return zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             zero
);

    // Operation select; reserved codes fall through to the zero default
    always_comb begin
        result = '0;
        case (op)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLT: result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule : alu
`default_nettype wire

// File: rtl/execute_top.sv
`default_nettype none
// ============================================================================
//  Module      : execute_top
//  Description : Execute stage of a 5-stage RISC-V style pipeline. Holds the
//                ID/EX pipeline register (with bubble insertion on FlushE),
//                the operand forwarding muxes, the ALU and the branch/jump
//                target and redirect logic.
//  Options     : EXECUTE_FORWARD_EN - when defined, ForwardAE/ForwardBE select
//                operands from ALUResultM / ResultW. When undefined the
//                forwarding ports remain but are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module execute_top
    import pipeline_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,

    // Decode-stage control
    input  logic             RegWriteD,
    input  logic             MemWriteD,
    input  logic             JumpD,
    input  logic             BranchD,
    input  logic             ALUSrcD,
    input  logic             JALRctrlD,
    input  logic [1:0]       ResultSrcD,
    input  logic [2:0]       ALUControlD,

    // Decode-stage data
    input  logic [WIDTH-1:0] RD1D,
    input  logic [WIDTH-1:0] RD2D,
    input  logic [WIDTH-1:0] PCD,
    input  logic [WIDTH-1:0] ImmExtD,
    input  logic [WIDTH-1:0] PCPlus4D,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       RdD,

    // Hazard unit
    input  logic             FlushE,
    input  logic [1:0]       ForwardAE,
    input  logic [1:0]       ForwardBE,
    input  logic [WIDTH-1:0] ALUResultM,
    input  logic [WIDTH-1:0] ResultW,

    // Fetch redirect
    output logic             PCsrcE,
    output logic [WIDTH-1:0] PCTargetE,

    // To memory stage / hazard unit
    output logic             RegWriteE,
    output logic             MemWriteE,
    output logic [1:0]       ResultSrcE,
    output logic [WIDTH-1:0] ALUResultE,
    output logic [WIDTH-1:0] WriteDataE,
    output logic [WIDTH-1:0] PCPlus4E,
    output logic [4:0]       Rs1E,
    output logic [4:0]       Rs2E,
    output logic [4:0]       RdE
);

    // ------------------------------------------------------------------
    // ID/EX pipeline register contents
    // ------------------------------------------------------------------
    logic             r_reg_write;
    logic             r_mem_write;
    logic             r_jump;
    logic             r_branch;
    logic             r_alu_src;
    logic             r_jalr;
    logic [1:0]       r_result_src;
    logic [2:0]       r_alu_ctrl;
    logic [WIDTH-1:0] r_rd1;
    logic [WIDTH-1:0] r_rd2;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_imm;
    logic [WIDTH-1:0] r_pc_plus4;
    logic [4:0]       r_rs1;
    logic [4:0]       r_rs2;
    logic [4:0]       r_rd;

    // ------------------------------------------------------------------
    // Execute-stage combinational nets
    // ------------------------------------------------------------------
    logic [WIDTH-1:0] w_src_a;
    logic [WIDTH-1:0] w_src_b;
    logic [WIDTH-1:0] w_write_data;
    logic [WIDTH-1:0] w_alu_result;
    logic             w_zero;
    logic [WIDTH-1:0] w_jalr_sum;
    logic [WIDTH-1:0] w_pc_rel;

    // ID/EX capture: a flush inserts a bubble by zeroing every field that
    // could cause an architectural side effect; data fields are still
    // captured since nothing downstream consumes them in a bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_reg_write  <= 1'b0;
            r_mem_write  <= 1'b0;
            r_jump       <= 1'b0;
            r_branch     <= 1'b0;
            r_alu_src    <= 1'b0;
            r_jalr       <= 1'b0;
            r_result_src <= 2'b00;
            r_alu_ctrl   <= 3'b000;
            r_rd1        <= '0;
            r_rd2        <= '0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_pc_plus4   <= '0;
            r_rs1        <= 5'd0;
            r_rs2        <= 5'd0;
            r_rd         <= 5'd0;
        end else begin
            r_alu_src    <= ALUSrcD;
            r_result_src <= ResultSrcD;
            r_alu_ctrl   <= ALUControlD;
            r_rd1        <= RD1D;
            r_rd2        <= RD2D;
            r_pc         <= PCD;
            r_imm        <= ImmExtD;
            r_pc_plus4   <= PCPlus4D;
            if (FlushE) begin
                r_reg_write <= 1'b0;
                r_mem_write <= 1'b0;
                r_jump      <= 1'b0;
                r_branch    <= 1'b0;
                r_jalr      <= 1'b0;
                r_rs1       <= 5'd0;
                r_rs2       <= 5'd0;
                r_rd        <= 5'd0;
            end else begin
                r_reg_write <= RegWriteD;
                r_mem_write <= MemWriteD;
                r_jump      <= JumpD;
                r_branch    <= BranchD;
                r_jalr      <= JALRctrlD;
                r_rs1       <= Rs1D;
                r_rs2       <= Rs2D;
                r_rd        <= RdD;
            end
        end
    end

`ifdef EXECUTE_FORWARD_EN
    // Operand A forwarding: newest producer (memory stage) beats write-back
    always_comb begin
        w_src_a = r_rd1;
        case (ForwardAE)
            FWD_WB:  w_src_a = ResultW;
            FWD_MEM: w_src_a = ALUResultM;
            default: w_src_a = r_rd1;
        endcase
    end

    // Operand B forwarding; this value is also the store data
    always_comb begin
        w_write_data = r_rd2;
        case (ForwardBE)
            FWD_WB:  w_write_data = ResultW;
            FWD_MEM: w_write_data = ALUResultM;
            default: w_write_data = r_rd2;
        endcase
    end
`else
    // Forwarding disabled: operands come straight from the register file
    logic w_unused_fwd;

    assign w_src_a      = r_rd1;
    assign w_write_data = r_rd2;
    assign w_unused_fwd = ^{ForwardAE, ForwardBE, ALUResultM, ResultW};
`endif

    assign w_src_b = r_alu_src ? r_imm : w_write_data;

    alu #(
        .WIDTH  (WIDTH)
    ) u_alu (
        .a      (w_src_a),
        .b      (w_src_b),
        .op     (r_alu_ctrl),
        .result (w_alu_result),
        .zero   (w_zero)
    );

    // Branch/jump target: JALR is register-relative with bit 0 forced low,
    // everything else is PC-relative
    assign w_jalr_sum = w_src_a + r_imm;
    assign w_pc_rel   = r_pc + r_imm;
    assign PCTargetE  = r_jalr ? {w_jalr_sum[WIDTH-1:1], 1'b0} : w_pc_rel;

    // Redirect on any jump, or on a branch whose compare result is zero
    assign PCsrcE     = r_jump | (r_branch & w_zero);

    assign ALUResultE = w_alu_result;
    assign WriteDataE = w_write_data;
    assign RegWriteE  = r_reg_write;
    assign MemWriteE  = r_mem_write;
    assign ResultSrcE = r_result_src;
    assign PCPlus4E   = r_pc_plus4;
    assign Rs1E       = r_rs1;
    assign Rs2E       = r_rs2;
    assign RdE        = r_rd;

endmodule : execute_top
`default_nettype wire

// File: tb/tb_execute_top.sv
`default_nettype none
// ============================================================================
//  Module      : tb_execute_top
//  Description : Scoreboard bench for execute_top. The stimulus process loads
//                one ID/EX vector per cycle and queues its hand-computed
//                E-stage result; a monitor pops and compares on each falling
//                edge. Reset behaviour is checked inline.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_execute_top;

    localparam int W = 32;

    logic         clk;
    logic         rst;
    logic         RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD;
    logic [1:0]   ResultSrcD;
    logic [2:0]   ALUControlD;
    logic [W-1:0] RD1D, RD2D, PCD, ImmExtD, PCPlus4D;
    logic [4:0]   Rs1D, Rs2D, RdD;
    logic         FlushE;
    logic [1:0]   ForwardAE, ForwardBE;
    logic [W-1:0] ALUResultM, ResultW;
    logic         PCsrcE;
    logic [W-1:0] PCTargetE;
    logic         RegWriteE, MemWriteE;
    logic [1:0]   ResultSrcE;
    logic [W-1:0] ALUResultE, WriteDataE, PCPlus4E;
    logic [4:0]   Rs1E, Rs2E, RdE;

    execute_top #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .JumpD(JumpD),
        .BranchD(BranchD), .ALUSrcD(ALUSrcD), .JALRctrlD(JALRctrlD),
        .ResultSrcD(ResultSrcD), .ALUControlD(ALUControlD),
        .RD1D(RD1D), .RD2D(RD2D), .PCD(PCD), .ImmExtD(ImmExtD),
        .PCPlus4D(PCPlus4D), .Rs1D(Rs1D), .Rs2D(Rs2D), .RdD(RdD),
        .FlushE(FlushE), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ALUResultM(ALUResultM), .ResultW(ResultW),
        .PCsrcE(PCsrcE), .PCTargetE(PCTargetE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .ResultSrcE(ResultSrcE),
        .ALUResultE(ALUResultE), .WriteDataE(WriteDataE), .PCPlus4E(PCPlus4E),
        .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic         regwrite, memwrite, jump, branch, alusrc, jalr, flush;
        logic [1:0]   resultsrc;
        logic [2:0]   aluctrl;
        logic [W-1:0] rd1, rd2, pc, imm, pcp4;
        logic [4:0]   rs1, rs2, rd;
        logic [1:0]   fa, fb;
        logic [W-1:0] alum, resw;
    } vec_t;

    typedef struct packed {
        logic         chk_data;
        logic         pcsrc, regwrite, memwrite;
        logic [1:0]   resultsrc;
        logic [W-1:0] pctarget, alu, wdata, pcp4;
        logic [4:0]   rs1, rs2, rd;
    } exp_t;

    vec_t  v;
    exp_t  e;
    exp_t  exp_q[$];
    string name_q[$];
    int    n_pass = 0;
    int    n_total = 0;

    task automatic check(input string nm, input logic [W-1:0] act, input logic [W-1:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, req);
    endtask

    task automatic check_zero(input string tag);
        check({tag, ".PCsrcE"},     W'(PCsrcE),     '0);
        check({tag, ".PCTargetE"},  PCTargetE,      '0);
        check({tag, ".RegWriteE"},  W'(RegWriteE),  '0);
        check({tag, ".MemWriteE"},  W'(MemWriteE),  '0);
        check({tag, ".ResultSrcE"}, W'(ResultSrcE), '0);
        check({tag, ".ALUResultE"}, ALUResultE,     '0);
        check({tag, ".WriteDataE"}, WriteDataE,     '0);
        check({tag, ".PCPlus4E"},   PCPlus4E,       '0);
        check({tag, ".RdE"},        W'(RdE),        '0);
        check({tag, ".Rs1E"},       W'(Rs1E),       '0);
        check({tag, ".Rs2E"},       W'(Rs2E),       '0);
    endtask

    task automatic drive_d();
        RegWriteD = v.regwrite;  MemWriteD = v.memwrite; JumpD = v.jump;
        BranchD = v.branch;      ALUSrcD = v.alusrc;     JALRctrlD = v.jalr;
        ResultSrcD = v.resultsrc; ALUControlD = v.aluctrl; FlushE = v.flush;
        RD1D = v.rd1; RD2D = v.rd2; PCD = v.pc; ImmExtD = v.imm; PCPlus4D = v.pcp4;
        Rs1D = v.rs1; Rs2D = v.rs2; RdD = v.rd;
    endtask

    // One vector: D fields before the edge, forward sources while it sits in E
    task automatic run(input string nm);
        @(negedge clk);
        drive_d();
        @(posedge clk);
        #1;
        ForwardAE = v.fa; ForwardBE = v.fb; ALUResultM = v.alum; ResultW = v.resw;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    task automatic clr();
        v = '0;
        e = '0;
        e.chk_data = 1'b1;
    endtask

    // Monitor: compare the oldest queued expectation on every falling edge
    initial begin
        exp_t  ex;
        string nm;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                ex = exp_q.pop_front();
                nm = name_q.pop_front();
                check({nm, ".PCsrcE"},    W'(PCsrcE),    W'(ex.pcsrc));
                check({nm, ".RegWriteE"}, W'(RegWriteE), W'(ex.regwrite));
                check({nm, ".MemWriteE"}, W'(MemWriteE), W'(ex.memwrite));
                check({nm, ".RdE"},       W'(RdE),       W'(ex.rd));
                check({nm, ".Rs1E"},      W'(Rs1E),      W'(ex.rs1));
                check({nm, ".Rs2E"},      W'(Rs2E),      W'(ex.rs2));
                if (ex.chk_data) begin
                    check({nm, ".ResultSrcE"}, W'(ResultSrcE), W'(ex.resultsrc));
                    check({nm, ".PCTargetE"},  PCTargetE,      ex.pctarget);
                    check({nm, ".ALUResultE"}, ALUResultE,     ex.alu);
                    check({nm, ".WriteDataE"}, WriteDataE,     ex.wdata);
                    check({nm, ".PCPlus4E"},   PCPlus4E,       ex.pcp4);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset held with busy decode inputs; E outputs must stay zero
        rst = 1'b0;
        clr();
        v.regwrite = 1'b1; v.jump = 1'b1; v.memwrite = 1'b1; v.resultsrc = 2'b10;
        v.rd1 = 32'h11; v.rd2 = 32'h22; v.pc = 32'h300; v.imm = 32'h8;
        v.pcp4 = 32'h304; v.rs1 = 5'd3; v.rs2 = 5'd4; v.rd = 5'd5;
        drive_d();
        ForwardAE = 2'b00; ForwardBE = 2'b00; ALUResultM = '0; ResultW = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_zero("reset_held");
        rst = 1'b1;
        #1;
        check_zero("reset_release");

        // add with memory-stage forward on A
        clr();
        v.regwrite = 1; v.alusrc = 1; v.aluctrl = 3'b000; v.rd1 = 5; v.imm = 3;
        v.rd2 = 9; v.pc = 32'h100; v.pcp4 = 32'h104; v.rs1 = 1; v.rs2 = 2; v.rd = 5;
        v.fa = 2'b10; v.alum = 7;
        e.regwrite = 1; e.rs1 = 1; e.rs2 = 2; e.rd = 5;
        e.pctarget = 32'h103; e.wdata = 9; e.pcp4 = 32'h104;
`ifdef EXECUTE_FORWARD_EN
        e.alu = 10;
`else
        e.alu = 8;
`endif
        run("add_fwdA");

        // BEQ taken: equal operands, negative offset
        clr();
        v.branch = 1; v.aluctrl = 3'b001; v.rd1 = 32'h1234; v.rd2 = 32'h1234;
        v.pc = 32'h40; v.imm = 32'hFFFF_FFF8; v.pcp4 = 32'h44; v.rs1 = 3; v.rs2 = 4;
        e.pcsrc = 1; e.pctarget = 32'h38; e.alu = 0; e.wdata = 32'h1234;
        e.pcp4 = 32'h44; e.rs1 = 3; e.rs2 = 4;
        run("beq_taken");

        // BEQ not taken
        clr();
        v.branch = 1; v.aluctrl = 3'b001; v.rd1 = 32'h1234; v.rd2 = 32'h1235;
        v.pc = 32'h40; v.imm = 32'hFFFF_FFF8; v.pcp4 = 32'h44; v.rs1 = 3; v.rs2 = 4;
        e.pcsrc = 0; e.pctarget = 32'h38; e.alu = 32'hFFFF_FFFF; e.wdata = 32'h1235;
        e.pcp4 = 32'h44; e.rs1 = 3; e.rs2 = 4;
        run("beq_not_taken");

        // JALR clears bit 0 of the register-relative target
        clr();
        v.jump = 1; v.jalr = 1; v.regwrite = 1; v.resultsrc = 2'b10; v.alusrc = 1;
        v.rd1 = 32'h101; v.imm = 4; v.pc = 32'h204; v.pcp4 = 32'h208; v.rs1 = 6; v.rd = 1;
        e.pcsrc = 1; e.regwrite = 1; e.resultsrc = 2'b10; e.pctarget = 32'h104;
        e.alu = 32'h105; e.wdata = 0; e.pcp4 = 32'h208; e.rs1 = 6; e.rd = 1;
        run("jalr");

        // Flush wins over live controls
        clr();
        v.flush = 1; v.regwrite = 1; v.memwrite = 1; v.jump = 1;
        v.rd = 7; v.rs1 = 8; v.rs2 = 9; v.rd1 = 32'hAA; v.pc = 32'h500;
        e.chk_data = 0;
        run("flush");

        // Signed SLT: -1 < 1
        clr();
        v.memwrite = 1; v.resultsrc = 2'b01; v.aluctrl = 3'b101;
        v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.imm = 32'h10; v.pcp4 = 4;
        e.memwrite = 1; e.resultsrc = 2'b01; e.alu = 1; e.wdata = 1;
        e.pctarget = 32'h10; e.pcp4 = 4;
        run("slt_signed");

        // Reserved op 110 yields zero
        clr();
        v.aluctrl = 3'b110; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1; v.imm = 32'h10;
        e.alu = 0; e.wdata = 1; e.pctarget = 32'h10;
        run("op110");

        // Reserved op 111 yields zero, so a branch on it is taken
        clr();
        v.branch = 1; v.aluctrl = 3'b111; v.rd1 = 32'hFFFF_FFFF; v.rd2 = 1;
        v.pc = 32'h10; v.imm = 8; v.pcp4 = 32'h14;
        e.pcsrc = 1; e.alu = 0; e.wdata = 1; e.pctarget = 32'h18; e.pcp4 = 32'h14;
        run("op111_branch");

        // Add wraps into the sign bit
        clr();
        v.alusrc = 1; v.rd1 = 32'h7FFF_FFFF; v.imm = 1;
        e.alu = 32'h8000_0000; e.pctarget = 1;
        run("add_wrap");

        // Subtract wraps below zero
        clr();
        v.aluctrl = 3'b001; v.rd1 = 0; v.rd2 = 1;
        e.alu = 32'hFFFF_FFFF; e.wdata = 1;
        run("sub_wrap");

        // Logic ops
        clr();
        v.aluctrl = 3'b010; v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00;
        e.alu = 32'hF000; e.wdata = 32'hFF00;
        run("and");
        clr();
        v.aluctrl = 3'b011; v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00;
        e.alu = 32'hFFF0; e.wdata = 32'hFF00;
        run("or");
        clr();
        v.aluctrl = 3'b100; v.rd1 = 32'hF0F0; v.rd2 = 32'hFF00;
        e.alu = 32'h0FF0; e.wdata = 32'hFF00;
        run("xor");

        // Write-back forward on B feeds both ALU and store data
        clr();
        v.memwrite = 1; v.rd1 = 32'h10; v.rd2 = 32'h11; v.fb = 2'b01; v.resw = 32'h55;
        e.memwrite = 1;
`ifdef EXECUTE_FORWARD_EN
        e.alu = 32'h65; e.wdata = 32'h55;
`else
        e.alu = 32'h21; e.wdata = 32'h11;
`endif
        run("fwdB_wb");

        // Select 11 falls back to the register value
        clr();
        v.alusrc = 1; v.rd1 = 32'h20; v.imm = 2; v.fa = 2'b11; v.alum = 32'h999;
        e.alu = 32'h22; e.pctarget = 2;
        run("fwdA_11");

        // JALR using a write-back forwarded base
        clr();
        v.jump = 1; v.jalr = 1; v.alusrc = 1; v.rd1 = 32'h500; v.imm = 32'h10;
        v.fa = 2'b01; v.resw = 32'h301;
        e.pcsrc = 1;
`ifdef EXECUTE_FORWARD_EN
        e.alu = 32'h311; e.pctarget = 32'h310;
`else
        e.alu = 32'h510; e.pctarget = 32'h510;
`endif
        run("jalr_fwd");

        // Jump in E, then reset mid-cycle must drop the redirect at once
        clr();
        v.jump = 1; v.regwrite = 1; v.resultsrc = 2'b10; v.alusrc = 1;
        v.rd1 = 1; v.imm = 32'h20; v.pc = 32'h80; v.pcp4 = 32'h84; v.rd = 1;
        e.pcsrc = 1; e.regwrite = 1; e.resultsrc = 2'b10; e.alu = 32'h21;
        e.pctarget = 32'hA0; e.pcp4 = 32'h84; e.rd = 1;
        run("jal");
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("midrst.PCsrcE_immediate", W'(PCsrcE), '0);
        check_zero("midrst_low");
        @(posedge clk);
        @(negedge clk);
        check_zero("midrst_held");
        rst = 1'b1;
        #1;
        check_zero("midrst_release");

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
        if (exp_q.size() > 0) begin
            n_total++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_execute_top
`default_nettype wire

// File: doc/execute_top.md
EXECUTE_TOP -- requirements
Module: execute_top

Interface
REQ-001 Parameter WIDTH, default 32, datapath width.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, JALRctrlD  input  1 each  decode control.
REQ-005 ResultSrcD  input  2  result select; ALUControlD  input  3  ALU op.
REQ-006 RD1D, RD2D, PCD, ImmExtD, PCPlus4D  input  WIDTH each  decode data.
REQ-007 Rs1D, Rs2D, RdD  input  5 each  register indices.
REQ-008 FlushE  input  1  synchronous bubble insert from hazard unit.
REQ-009 ForwardAE, ForwardBE  input  2 each  operand forward selects.
REQ-010 ALUResultM, ResultW  input  WIDTH each  forward sources.
REQ-011 PCsrcE  output  1  redirect fetch; PCTargetE  output  WIDTH  redirect address.
REQ-012 RegWriteE, MemWriteE  output  1 each; ResultSrcE  output  2  to memory stage.
REQ-013 ALUResultE, WriteDataE, PCPlus4E  output  WIDTH each  to memory stage.
REQ-014 Rs1E, Rs2E, RdE  output  5 each  to hazard unit / memory stage.

Function
REQ-015 ID/EX register SHALL capture every D input on each rising clk; latency one cycle D->E.
REQ-016 FlushE=1 at an edge SHALL load all control fields (RegWrite, MemWrite, Jump, Branch, JALRctrl) and Rs1/Rs2/Rd as 0; data fields don't-care; FlushE wins over capture.
REQ-017 SrcAE: ForwardAE 00 -> RD1E, 01 -> ResultW, 10 -> ALUResultM, 11 -> RD1E.
REQ-018 WriteDataE: same mapping on ForwardBE over RD2E.
REQ-019 SrcBE = ALUSrcE ? ImmExtE : WriteDataE.
REQ-020 ALU combinational: 000 add, 001 sub, 010 and, 011 or, 100 xor, 101 signed slt (result 0/1 zero-extended), 110/111 -> 0; add/sub wrap modulo 2^WIDTH, no overflow flag.
REQ-021 ZeroE = (ALUResultE == 0).
REQ-022 PCTargetE = JALRctrlE ? ((SrcAE + ImmExtE) with bit 0 cleared) : (PCE + ImmExtE), modulo 2^WIDTH.
REQ-023 PCsrcE = JumpE | (BranchE & ZeroE), combinational from E register and forwarded operands.
REQ-024 Control outputs RegWriteE, MemWriteE, ResultSrcE, RdE SHALL be the registered values unmodified.

Reset
REQ-025 rst low SHALL asynchronously clear every E register to 0; while low and after release until first capture: PCsrcE=0, RegWriteE=0, MemWriteE=0, ResultSrcE=00, RdE=0, Rs1E=Rs2E=0, PCTargetE=ImmExtE+PCE=0, ALUResultE=0.
REQ-026 Reset mid-branch SHALL drop PCsrcE the same cycle rst falls.

Configuration
REQ-027 Macro EXECUTE_FORWARD_EN defined: forwarding per REQ-017/018.
REQ-028 Macro undefined: ForwardAE/BE, ALUResultM, ResultW ignored; SrcAE=RD1E, WriteDataE=RD2E; ports remain present.

Structure
REQ-029 Shared package pipeline_pkg SHALL hold ALU op codes, forward-select codes (FWD_REG, FWD_WB, FWD_MEM) and WIDTH default.
REQ-030 ALU SHALL be sub-module alu (inputs a, b, op; outputs result, zero); register and muxes in execute_top.

Verification
REQ-031 Reset: rst low mid-run with JumpE=1 -> PCsrcE=0 immediately, all E outputs 0 after release.
REQ-032 Add/forward: RD1D=5, ALUResultM=7, ForwardAE=10, ImmExtD=3, ALUSrcD=1, op 000 -> ALUResultE=10 next cycle (5+3=8 without EXECUTE_FORWARD_EN).
REQ-033 BEQ taken: BranchD=1, op 001, RD1D=RD2D=0x1234, PCD=0x40, ImmExtD=0xFFFFFFF8 -> PCsrcE=1, PCTargetE=0x38.
REQ-034 JALR: JumpD=1, JALRctrlD=1, RD1D=0x101, ImmExtD=4 -> PCsrcE=1, PCTargetE=0x104, PCPlus4E=PCPlus4D.
REQ-035 Flush: FlushE=1 with RegWriteD=1, MemWriteD=1, JumpD=1 -> next cycle RegWriteE=0, MemWriteE=0, PCsrcE=0, RdE=0.
REQ-036 SLT signed: SrcA=0xFFFFFFFF, SrcB=1, op 101 -> ALUResultE=1; op 110 -> 0; 0x7FFFFFFF+1 op 000 -> 0x80000000.
